// File: rtl/frac_reduce_div_pkg.sv
// Shared types and helpers for the fraction-reduction divider.
package frac_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV_N = 2'd1,
    S_DIV_D = 2'd2,
    S_OUT   = 2'd3
  } frd_st_e;

  // Width of a counter that must hold WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/frac_reduce_div_if.sv
// Input-triple and result handshake bundle for frac_reduce_div.
interface frac_reduce_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_num;
  logic [WIDTH-1:0] in_den;
  logic [WIDTH-1:0] in_gcd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_num;
  logic [WIDTH-1:0] out_den;
  logic             out_err;

  // Producer/consumer side.
  modport master (
    output in_valid, in_num, in_den, in_gcd, out_ready,
    input  in_ready, out_valid, out_num, out_den, out_err
  );

  // The reducer itself.
  modport slave (
    input  in_valid, in_num, in_den, in_gcd, out_ready,
    output in_ready, out_valid, out_num, out_den, out_err
  );
endinterface

// File: rtl/frac_reduce_div_serial_udiv.sv
// Serial unsigned restoring divider, one quotient bit per step.
// quotient/remainder show the result of the step taken at the next edge, so the
// sequencer can capture the final values on the same edge as the last step.
module serial_udiv
  import frac_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             step,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH:0]   remainder,
  output logic             last
);
  localparam int unsigned CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH:0]   rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;

  // Trial subtraction; rem < divisor keeps the sign in trial[WIDTH].
  always_comb begin
    shifted   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    trial     = shifted - {1'b0, divisor};
    qbit      = ~trial[WIDTH];
    remainder = qbit ? trial : shifted;
    quotient  = {dvd_q[WIDTH-2:0], qbit};
    last      = (cnt_q == '0);
  end

  // Load has priority so the sequencer can chain the second operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      dvd_q <= dividend;
      rem_q <= '0;
      cnt_q <= CW'(WIDTH - 1);
    end else if (step) begin
      dvd_q <= quotient;
      rem_q <= remainder;
      cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/frac_reduce_div.sv
// Reduces num/den by a supplied gcd, running one shared serial divider twice.
module frac_reduce_div
  import frac_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  frac_reduce_div_if.slave  bus
);
  frd_st_e          st_q, st_d;
  logic [WIDTH-1:0] den_q, gcd_q, onum_q, oden_q;
  logic             err_q;
  logic             accept;
  logic             div_load, div_step, div_last;
  logic [WIDTH-1:0] div_dividend, div_quot;
  logic [WIDTH:0]   div_rem;

  assign accept        = (st_q == S_IDLE) && bus.in_valid;
  assign div_step      = (st_q == S_DIV_N) || (st_q == S_DIV_D);
  assign bus.in_ready  = (st_q == S_IDLE);
  assign bus.out_valid = (st_q == S_OUT);
  assign bus.out_num   = onum_q;
  assign bus.out_den   = oden_q;
  assign bus.out_err   = err_q;

  serial_udiv #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .dividend  (div_dividend),
    .divisor   (gcd_q),
    .step      (div_step),
    .quotient  (div_quot),
    .remainder (div_rem),
    .last      (div_last)
  );

  // Next state and divider load sequencing.
  always_comb begin
    st_d         = st_q;
    div_load     = 1'b0;
    div_dividend = bus.in_num;
    case (st_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.in_gcd == '0) begin
            st_d = S_OUT;
          end else begin
            div_load = 1'b1;
            st_d     = S_DIV_N;
          end
        end
      end
      S_DIV_N: begin
        if (div_last) begin
          div_load     = 1'b1;
          div_dividend = den_q;
          st_d         = S_DIV_D;
        end
      end
      S_DIV_D: if (div_last) st_d = S_OUT;
      S_OUT:   if (bus.out_ready) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= S_IDLE;
    else        st_q <= st_d;
  end

  // Operand capture and result/error accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      den_q  <= '0;
      gcd_q  <= '0;
      onum_q <= '0;
      oden_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        den_q <= bus.in_den;
        gcd_q <= bus.in_gcd;
        err_q <= (bus.in_gcd == '0);
        if (bus.in_gcd == '0) begin
          // Pass the fraction through unreduced.
          onum_q <= bus.in_num;
          oden_q <= bus.in_den;
        end
      end
      if (st_q == S_DIV_N && div_last) begin
        onum_q <= div_quot;
        err_q  <= err_q | (div_rem != '0);
      end
      if (st_q == S_DIV_D && div_last) begin
        oden_q <= div_quot;
        err_q  <= err_q | (div_rem != '0);
      end
    end
  end
endmodule

// File: tb/tb_frac_reduce_div.sv
// Directed bench for frac_reduce_div at WIDTH=32.
module tb_frac_reduce_div;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  frac_reduce_div_if #(.WIDTH(32)) bus ();

  frac_reduce_div #(
    .WIDTH(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one triple, measure accept-to-valid latency, check result, then drain.
  task automatic run(input string tag, input logic [31:0] num, input logic [31:0] den,
                     input logic [31:0] gcd, input logic [31:0] e_num,
                     input logic [31:0] e_den, input logic e_err, input int e_lat);
    int lat;
    check({tag, "_rdy"}, 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.in_num   = num;
    bus.in_den   = den;
    bus.in_gcd   = gcd;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(e_lat));
    check({tag, "_res"}, {bus.out_num, bus.out_den, 31'd0, bus.out_err},
          {e_num, e_den, 31'd0, e_err});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_done"}, {126'd0, bus.in_ready, bus.out_valid}, 128'b10);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.in_den    = '0;
    bus.in_gcd    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out", {bus.out_valid, bus.out_err, bus.out_num, bus.out_den}, 128'd0);
    rst_n = 1'b1;
    tick();
    check("rst_rdy", 128'(bus.in_ready), 128'(1));

    run("basic",   32'd12, 32'd18, 32'd6, 32'd2, 32'd3, 1'b0, 65);
    run("zeronum", 32'd0,  32'd7,  32'd7, 32'd0, 32'd1, 1'b0, 65);
    run("gcd0",    32'd5,  32'd9,  32'd0, 32'd5, 32'd9, 1'b1, 1);
    run("nodiv",   32'd10, 32'd12, 32'd4, 32'd2, 32'd3, 1'b1, 65);
    run("max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 65);
    run("mixed",   32'd7,  32'd21, 32'd7, 32'd1, 32'd3, 1'b0, 65);

    // Backpressure: hold the 12/18 result for 20 cycles.
    bus.in_valid = 1'b1;
    bus.in_num   = 32'd12;
    bus.in_den   = 32'd18;
    bus.in_gcd   = 32'd6;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 64; i++) tick();
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {bus.in_ready, bus.out_valid, bus.out_num, bus.out_den, bus.out_err},
            {1'b0, 1'b1, 32'd2, 32'd3, 1'b0});
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_done", 128'(bus.in_ready), 128'(1));

    // Reset during the denominator pass of 100/50.
    bus.in_valid = 1'b1;
    bus.in_num   = 32'd100;
    bus.in_den   = 32'd50;
    bus.in_gcd   = 32'd50;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("mid_num", 128'(bus.out_num), 128'(2));
    rst_n = 1'b0;
    #1;
    check("mid_rst", {bus.out_valid, bus.out_err, bus.out_num, bus.out_den}, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rdy", {bus.in_ready, bus.out_valid}, 128'b10);

    run("after", 32'd8, 32'd4, 32'd4, 32'd2, 32'd1, 1'b0, 65);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
